// File: rtl/ula_scheduler_if.sv
// Bus bundle between the two ULA requesters, the scheduler and the ULA itself.
// The scheduler takes the slave view. The requesters and the ULA take the master view.
interface ula_scheduler_if #(
  parameter int W = 32
);
  // Requester side
  logic         req0;
  logic         req1;
  logic [4:0]   op0;
  logic [4:0]   op1;
  logic [W-1:0] a0;
  logic [W-1:0] a1;
  logic [W-1:0] b0;
  logic [W-1:0] b1;
  logic         done0;
  logic         done1;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
  logic         err;
  logic         busy;

  // ULA side
  logic [4:0]   alu_opcode;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_out;
  logic         alu_carry;

  modport slave (
    input  req0, req1, op0, op1, a0, a1, b0, b1, alu_out, alu_carry,
    output done0, done1, result, zero, carry, err, busy,
           alu_opcode, alu_a, alu_b
  );

  modport master (
    output req0, req1, op0, op1, a0, a1, b0, b1, alu_out, alu_carry,
    input  done0, done1, result, zero, carry, err, busy,
           alu_opcode, alu_a, alu_b
  );
endinterface

// File: rtl/ula_scheduler.sv
// Round-robin scheduler that shares one combinational ULA between the
// fetch/PC path (requester 0) and the execute path (requester 1).
// The scheduler registers the winning operands and holds the opcode for SETTLE cycles.
// It then captures the result and flags and pulses the winner's done output.
// The opcode returns to IDLE_OPCODE between operations. Every operation
// therefore presents a fresh opcode transition to the ULA.
module ula_scheduler #(
  parameter int         W           = 32,
  parameter int         SETTLE      = 1,
  parameter logic [4:0] IDLE_OPCODE = 5'b10000
) (
  input  logic            clk,
  input  logic            rst,
  ula_scheduler_if.slave  bus
);

  localparam int                CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [W-1:0]      ZERO_W   = {W{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Opcodes the ULA does not implement. These are reported through err
  // without ever being presented to the ULA.
  function automatic logic illegal_op(input logic [4:0] op);
    logic bad;
    case (op)
      5'h02, 5'h07,
      5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F: bad = 1'b1;
      default:                                  bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Registered state and outputs
  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              last_grant_r;
  logic              winner_r;
  logic              done0_r;
  logic              done1_r;
  logic [W-1:0]      result_r;
  logic              zero_r;
  logic              carry_r;
  logic              err_r;
  logic              busy_r;
  logic [4:0]        alu_opcode_r;
  logic [W-1:0]      alu_a_r;
  logic [W-1:0]      alu_b_r;

  // Next-state values
  state_t            state_s;
  logic [CNT_W-1:0]  cnt_s;
  logic              last_grant_s;
  logic              winner_s;
  logic              done0_s;
  logic              done1_s;
  logic [W-1:0]      result_s;
  logic              zero_s;
  logic              carry_s;
  logic              err_s;
  logic              busy_s;
  logic [4:0]        alu_opcode_s;
  logic [W-1:0]      alu_a_s;
  logic [W-1:0]      alu_b_s;

  // Arbitration result
  logic              any_req_s;
  logic              pick_s;
  logic [4:0]        sel_op_s;
  logic [W-1:0]      sel_a_s;
  logic [W-1:0]      sel_b_s;

  // Round-robin pick: on a tie the requester that was not granted last wins
  always_comb begin
    any_req_s = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      pick_s = ~last_grant_r;
    end else begin
      pick_s = bus.req1;
    end
    if (pick_s) begin
      sel_op_s = bus.op1;
      sel_a_s  = bus.a1;
      sel_b_s  = bus.b1;
    end else begin
      sel_op_s = bus.op0;
      sel_a_s  = bus.a0;
      sel_b_s  = bus.b0;
    end
  end

  // Next-state and next-output logic for the IDLE -> EXEC -> DONE sequence
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    last_grant_s = last_grant_r;
    winner_s     = winner_r;
    done0_s      = 1'b0;
    done1_s      = 1'b0;
    result_s     = result_r;
    zero_s       = zero_r;
    carry_s      = carry_r;
    err_s        = err_r;
    alu_opcode_s = alu_opcode_r;
    alu_a_s      = alu_a_r;
    alu_b_s      = alu_b_r;

    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          winner_s     = pick_s;
          last_grant_s = pick_s;
          alu_a_s      = sel_a_s;
          alu_b_s      = sel_b_s;
          cnt_s        = {CNT_W{1'b0}};
          if (illegal_op(sel_op_s)) begin
            // Skip the ULA entirely. The opcode bus never leaves idle.
            state_s      = DONE;
            alu_opcode_s = IDLE_OPCODE;
            result_s     = ZERO_W;
            zero_s       = 1'b1;
            carry_s      = 1'b0;
            err_s        = 1'b1;
            done0_s      = ~pick_s;
            done1_s      = pick_s;
          end else begin
            state_s      = EXEC;
            alu_opcode_s = sel_op_s;
          end
        end else begin
          state_s = IDLE;
        end
      end

      EXEC: begin
        if (cnt_r == CNT_LAST) begin
          // Last settle cycle: capture the ULA output and drop the opcode.
          state_s      = DONE;
          alu_opcode_s = IDLE_OPCODE;
          result_s     = bus.alu_out;
          zero_s       = (bus.alu_out == ZERO_W);
          carry_s      = bus.alu_carry;
          err_s        = 1'b0;
          done0_s      = ~winner_r;
          done1_s      = winner_r;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      DONE: begin
        state_s = IDLE;
      end

      default: begin
        state_s      = IDLE;
        alu_opcode_s = IDLE_OPCODE;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State and output registers; reset aborts any in-flight operation silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      last_grant_r <= 1'b1;
      winner_r     <= 1'b0;
      done0_r      <= 1'b0;
      done1_r      <= 1'b0;
      result_r     <= ZERO_W;
      zero_r       <= 1'b0;
      carry_r      <= 1'b0;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
      alu_opcode_r <= IDLE_OPCODE;
      alu_a_r      <= ZERO_W;
      alu_b_r      <= ZERO_W;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      last_grant_r <= last_grant_s;
      winner_r     <= winner_s;
      done0_r      <= done0_s;
      done1_r      <= done1_s;
      result_r     <= result_s;
      zero_r       <= zero_s;
      carry_r      <= carry_s;
      err_r        <= err_s;
      busy_r       <= busy_s;
      alu_opcode_r <= alu_opcode_s;
      alu_a_r      <= alu_a_s;
      alu_b_r      <= alu_b_s;
    end
  end

  assign bus.done0      = done0_r;
  assign bus.done1      = done1_r;
  assign bus.result     = result_r;
  assign bus.zero       = zero_r;
  assign bus.carry      = carry_r;
  assign bus.err        = err_r;
  assign bus.busy       = busy_r;
  assign bus.alu_opcode = alu_opcode_r;
  assign bus.alu_a      = alu_a_r;
  assign bus.alu_b      = alu_b_r;

endmodule

// File: tb/tb_ula_scheduler.sv
// Bench for ula_scheduler. Instance A uses SETTLE=1 and instance B uses SETTLE=3.
// A transaction-level model predicts every output on every cycle. Literal
// expectations pin the key results.
module tb_ula_scheduler;

  localparam int W = 32;
  localparam int S_DONE0 = 0, S_DONE1 = 1, S_RES = 2, S_ZERO = 3, S_CARRY = 4;
  localparam int S_ERR = 5, S_OPC = 6, S_BUSY = 7, S_AA = 8, S_AB = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ula_scheduler_if #(.W(W)) bus_a ();
  ula_scheduler_if #(.W(W)) bus_b ();

  ula_scheduler #(.W(W), .SETTLE(1), .IDLE_OPCODE(5'h10)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  ula_scheduler #(.W(W), .SETTLE(3), .IDLE_OPCODE(5'h10)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Toy ULA: {carry, out}
  function automatic logic [32:0] ula_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'h00:   return {1'b0, a} + {1'b0, b};
      5'h01:   return {1'b0, a & b};
      5'h03:   return {1'b0, a | b};
      5'h05:   return {1'b0, a} - {1'b0, b};
      5'h10:   return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  assign {bus_a.alu_carry, bus_a.alu_out} = ula_fn(bus_a.alu_opcode, bus_a.alu_a, bus_a.alu_b);
  assign {bus_b.alu_carry, bus_b.alu_out} = ula_fn(bus_b.alu_opcode, bus_b.alu_a, bus_b.alu_b);

  function automatic logic is_illegal(input logic [4:0] op);
    return (op == 5'h02) || (op == 5'h07) || (op >= 5'h0A && op <= 5'h0F);
  endfunction

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic string sname(input int s);
    case (s)
      0: return "done0";   1: return "done1";  2: return "result";
      3: return "zero";    4: return "carry";  5: return "err";
      6: return "alu_opcode"; 7: return "busy"; 8: return "alu_a";
      9: return "alu_b";
      default: return "unknown";
    endcase
  endfunction

  // Literal expectations: checked by the compare process at the given cycle
  typedef struct {
    int          dut;
    int          cyc;
    int          sig;
    logic [31:0] val;
  } lit_t;
  lit_t lit_q[$];

  task automatic lit(input int d, input int c, input int s, input logic [31:0] v);
    lit_t e;
    e.dut = d; e.cyc = c; e.sig = s; e.val = v;
    lit_q.push_back(e);
  endtask

  // Counters and model state (written only by the compare process)
  int          n_checks = 0;
  int          n_fails  = 0;
  int          cyc      = 0;
  logic        finish_req = 1'b0;

  logic        m_act  [2];
  int          m_done [2];
  logic        m_win  [2];
  logic        m_last [2];
  logic        m_ill  [2];
  logic [4:0]  m_op   [2];
  logic [31:0] m_pres [2];
  logic        m_pcar [2];
  logic [31:0] m_a    [2];
  logic [31:0] m_b    [2];
  logic [31:0] h_res  [2];
  logic        h_zero [2];
  logic        h_car  [2];
  logic        h_err  [2];

  logic [31:0] got  [2][10];
  logic [31:0] expv [10];
  logic        rq0 [2], rq1 [2];
  logic [4:0]  o0 [2], o1 [2];
  logic [31:0] ia0 [2], ia1 [2], ib0 [2], ib1 [2];
  logic        mdl_w;
  logic [4:0]  mdl_op;
  logic [31:0] mdl_a, mdl_b;
  logic [32:0] mdl_r;

  task automatic check(input int d, input int s, input logic [31:0] act, input logic [31:0] ex, input string tag);
    n_checks++;
    if (act !== ex) begin
      n_fails++;
      $display("FAIL %s dut%0d %s cyc=%0d: got %h, expected %h", tag, d, sname(s), cyc, act, ex);
    end
  endtask

  // Compare process: model prediction and literal checks every cycle, away from the active edge
  always @(negedge clk) begin
    got[0][0] = 32'(bus_a.done0);  got[0][1] = 32'(bus_a.done1);
    got[0][2] = bus_a.result;      got[0][3] = 32'(bus_a.zero);
    got[0][4] = 32'(bus_a.carry);  got[0][5] = 32'(bus_a.err);
    got[0][6] = 32'(bus_a.alu_opcode); got[0][7] = 32'(bus_a.busy);
    got[0][8] = bus_a.alu_a;       got[0][9] = bus_a.alu_b;
    got[1][0] = 32'(bus_b.done0);  got[1][1] = 32'(bus_b.done1);
    got[1][2] = bus_b.result;      got[1][3] = 32'(bus_b.zero);
    got[1][4] = 32'(bus_b.carry);  got[1][5] = 32'(bus_b.err);
    got[1][6] = 32'(bus_b.alu_opcode); got[1][7] = 32'(bus_b.busy);
    got[1][8] = bus_b.alu_a;       got[1][9] = bus_b.alu_b;
    rq0[0] = bus_a.req0; rq1[0] = bus_a.req1; o0[0] = bus_a.op0; o1[0] = bus_a.op1;
    ia0[0] = bus_a.a0; ia1[0] = bus_a.a1; ib0[0] = bus_a.b0; ib1[0] = bus_a.b1;
    rq0[1] = bus_b.req0; rq1[1] = bus_b.req1; o0[1] = bus_b.op0; o1[1] = bus_b.op1;
    ia0[1] = bus_b.a0; ia1[1] = bus_b.a1; ib0[1] = bus_b.b0; ib1[1] = bus_b.b1;

    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_act[d] = 1'b0; m_last[d] = 1'b1; m_win[d] = 1'b0; m_ill[d] = 1'b0;
        m_a[d] = 32'd0; m_b[d] = 32'd0; m_op[d] = 5'h10;
        h_res[d] = 32'd0; h_zero[d] = 1'b0; h_car[d] = 1'b0; h_err[d] = 1'b0;
      end else if (m_act[d] && cyc == m_done[d]) begin
        h_res[d]  = m_pres[d];
        h_zero[d] = (m_pres[d] == 32'd0);
        h_car[d]  = m_pcar[d];
        h_err[d]  = m_ill[d];
      end
      expv[0] = 32'(m_act[d] && cyc == m_done[d] && !m_win[d]);
      expv[1] = 32'(m_act[d] && cyc == m_done[d] && m_win[d]);
      expv[2] = h_res[d];
      expv[3] = 32'(h_zero[d]);
      expv[4] = 32'(h_car[d]);
      expv[5] = 32'(h_err[d]);
      expv[6] = (m_act[d] && !m_ill[d] && cyc < m_done[d]) ? 32'(m_op[d]) : 32'h10;
      expv[7] = 32'(m_act[d]);
      expv[8] = m_a[d];
      expv[9] = m_b[d];
      for (int s = 0; s < 10; s++) check(d, s, got[d][s], expv[s], "model");

      if (!rst) begin
        for (int i = lit_q.size() - 1; i >= 0; i--) begin
          if (lit_q[i].dut == d && lit_q[i].cyc == cyc) begin
            check(d, lit_q[i].sig, got[d][lit_q[i].sig], lit_q[i].val, "literal");
            lit_q.delete(i);
          end
        end
        // Advance the model: a free scheduler accepts a request seen this cycle
        if (m_act[d]) begin
          if (cyc == m_done[d]) m_act[d] = 1'b0;
        end else if (rq0[d] || rq1[d]) begin
          mdl_w  = (rq0[d] && rq1[d]) ? ~m_last[d] : rq1[d];
          mdl_op = mdl_w ? o1[d]  : o0[d];
          mdl_a  = mdl_w ? ia1[d] : ia0[d];
          mdl_b  = mdl_w ? ib1[d] : ib0[d];
          mdl_r  = ula_fn(mdl_op, mdl_a, mdl_b);
          m_last[d] = mdl_w; m_win[d] = mdl_w; m_op[d] = mdl_op;
          m_a[d] = mdl_a; m_b[d] = mdl_b; m_ill[d] = is_illegal(mdl_op);
          m_pres[d] = m_ill[d] ? 32'd0 : mdl_r[31:0];
          m_pcar[d] = m_ill[d] ? 1'b0 : mdl_r[32];
          m_done[d] = cyc + (m_ill[d] ? 1 : settle_of(d) + 1);
          m_act[d]  = 1'b1;
        end
      end
    end

    if (rst) cyc = 0;
    else cyc = cyc + 1;

    if (finish_req) begin
      n_checks++;
      if (lit_q.size() != 0) begin
        n_fails++;
        $display("FAIL literal_leftover: %0d literal checks never reached, expected 0", lit_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_a.req0 = 1'b0; bus_a.req1 = 1'b0; bus_a.op0 = 5'h00; bus_a.op1 = 5'h00;
    bus_a.a0 = 32'd0; bus_a.a1 = 32'd0; bus_a.b0 = 32'd0; bus_a.b1 = 32'd0;
    bus_b.req0 = 1'b0; bus_b.req1 = 1'b0; bus_b.op0 = 5'h00; bus_b.op1 = 5'h00;
    bus_b.a0 = 32'd0; bus_b.a1 = 32'd0; bus_b.b0 = 32'd0; bus_b.b1 = 32'd0;
  endtask

  task automatic start_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
  endtask

  // Directed stimulus; cycle 0 is the cycle in which reset is released
  initial begin
    rst = 1'b1;
    clear_inputs();
    repeat (2) step();

    // 1: reset while req0's add is in EXEC: no done, opcode idle, result cleared
    rst = 1'b0;
    bus_a.req0 = 1'b1; bus_a.op0 = 5'h00; bus_a.a0 = 32'd5; bus_a.b0 = 32'd7;
    step();
    rst = 1'b1; bus_a.req0 = 1'b0;
    step(); step();
    lit(0, 0, S_RES, 32'd0); lit(0, 0, S_OPC, 32'h10);
    lit(0, 1, S_DONE0, 32'd0); lit(0, 2, S_DONE0, 32'd0); lit(0, 1, S_BUSY, 32'd0);
    rst = 1'b0;
    repeat (3) step();

    // 2: single add, done0 in cycle 2
    start_reset();
    lit(0, 1, S_BUSY, 32'd1); lit(0, 1, S_DONE0, 32'd0);
    lit(0, 2, S_DONE0, 32'd1); lit(0, 2, S_RES, 32'd12);
    lit(0, 2, S_ZERO, 32'd0); lit(0, 2, S_CARRY, 32'd0);
    rst = 1'b0;
    bus_a.req0 = 1'b1; bus_a.op0 = 5'h00; bus_a.a0 = 32'd5; bus_a.b0 = 32'd7;
    repeat (3) step();
    bus_a.req0 = 1'b0;
    repeat (2) step();

    // 3: both requesting continuously: grants alternate 0,1,0,1 every 3 cycles
    start_reset();
    lit(0, 2, S_DONE0, 32'd1); lit(0, 2, S_DONE1, 32'd0); lit(0, 3, S_BUSY, 32'd0);
    lit(0, 5, S_DONE1, 32'd1); lit(0, 5, S_DONE0, 32'd0); lit(0, 5, S_RES, 32'd30);
    lit(0, 8, S_DONE0, 32'd1); lit(0, 8, S_RES, 32'd3); lit(0, 11, S_DONE1, 32'd1);
    rst = 1'b0;
    bus_a.req0 = 1'b1; bus_a.op0 = 5'h00; bus_a.a0 = 32'd1;  bus_a.b0 = 32'd2;
    bus_a.req1 = 1'b1; bus_a.op1 = 5'h00; bus_a.a1 = 32'd10; bus_a.b1 = 32'd20;
    repeat (12) step();
    bus_a.req0 = 1'b0; bus_a.req1 = 1'b0;
    repeat (3) step();

    // 4: subtract to zero on requester 1
    start_reset();
    lit(0, 2, S_DONE1, 32'd1); lit(0, 2, S_RES, 32'd0);
    lit(0, 2, S_ZERO, 32'd1);  lit(0, 2, S_ERR, 32'd0);
    rst = 1'b0;
    bus_a.req1 = 1'b1; bus_a.op1 = 5'h05; bus_a.a1 = 32'd9; bus_a.b1 = 32'd9;
    repeat (3) step();
    bus_a.req1 = 1'b0;
    repeat (2) step();

    // 5: illegal opcodes complete one cycle after sampling with err, then a legal op clears err
    start_reset();
    lit(0, 2, S_DONE0, 32'd1); lit(0, 2, S_RES, 32'd12); lit(0, 3, S_OPC, 32'h10);
    lit(0, 4, S_DONE1, 32'd1); lit(0, 4, S_ERR, 32'd1); lit(0, 4, S_RES, 32'd0);
    lit(0, 4, S_ZERO, 32'd1); lit(0, 4, S_OPC, 32'h10); lit(0, 5, S_OPC, 32'h10);
    lit(0, 6, S_DONE0, 32'd1); lit(0, 6, S_DONE1, 32'd0); lit(0, 6, S_ERR, 32'd1);
    lit(0, 9, S_DONE1, 32'd1); lit(0, 9, S_ERR, 32'd0); lit(0, 9, S_RES, 32'd2);
    rst = 1'b0;
    bus_a.req0 = 1'b1; bus_a.op0 = 5'h00; bus_a.a0 = 32'd5; bus_a.b0 = 32'd7;
    repeat (3) step();
    bus_a.req0 = 1'b0;
    bus_a.req1 = 1'b1; bus_a.op1 = 5'h02; bus_a.a1 = 32'd3; bus_a.b1 = 32'd4;
    repeat (2) step();
    bus_a.req1 = 1'b0;
    bus_a.req0 = 1'b1; bus_a.op0 = 5'h07;
    repeat (2) step();
    bus_a.req0 = 1'b0;
    bus_a.req1 = 1'b1; bus_a.op1 = 5'h01; bus_a.a1 = 32'd6; bus_a.b1 = 32'd3;
    repeat (3) step();
    bus_a.req1 = 1'b0;
    repeat (2) step();

    // 6: carry out of the add; then an opcode equal to the idle opcode runs normally
    start_reset();
    lit(0, 2, S_DONE0, 32'd1); lit(0, 2, S_CARRY, 32'd1);
    lit(0, 2, S_RES, 32'd0);   lit(0, 2, S_ZERO, 32'd1);
    lit(0, 4, S_BUSY, 32'd1);  lit(0, 4, S_OPC, 32'h10);
    lit(0, 5, S_DONE1, 32'd1); lit(0, 5, S_RES, 32'd2); lit(0, 5, S_CARRY, 32'd0);
    rst = 1'b0;
    bus_a.req0 = 1'b1; bus_a.op0 = 5'h00; bus_a.a0 = 32'h8000_0000; bus_a.b0 = 32'h8000_0000;
    repeat (3) step();
    bus_a.req0 = 1'b0;
    bus_a.req1 = 1'b1; bus_a.op1 = 5'h10; bus_a.a1 = 32'd4; bus_a.b1 = 32'd6;
    repeat (3) step();
    bus_a.req1 = 1'b0;
    repeat (2) step();

    // 7: SETTLE=3: opcode held 3 cycles, idle opcode between back-to-back ops
    start_reset();
    lit(1, 1, S_OPC, 32'h03); lit(1, 2, S_OPC, 32'h03); lit(1, 3, S_OPC, 32'h03);
    lit(1, 3, S_DONE0, 32'd0); lit(1, 4, S_DONE0, 32'd1); lit(1, 4, S_RES, 32'hFF);
    lit(1, 4, S_OPC, 32'h10); lit(1, 5, S_OPC, 32'h10); lit(1, 5, S_BUSY, 32'd0);
    lit(1, 6, S_OPC, 32'h01); lit(1, 9, S_DONE0, 32'd1); lit(1, 9, S_RES, 32'd1);
    rst = 1'b0;
    bus_b.req0 = 1'b1; bus_b.op0 = 5'h03; bus_b.a0 = 32'hF0; bus_b.b0 = 32'h0F;
    repeat (5) step();
    bus_b.op0 = 5'h01; bus_b.a0 = 32'd1; bus_b.b0 = 32'd3;
    repeat (5) step();
    bus_b.req0 = 1'b0;
    repeat (3) step();

    finish_req = 1'b1;
    repeat (5) step();
    $display("FAIL end_of_test: compare process did not finish, expected finish");
    $fatal(1, "bench did not terminate");
  end

endmodule
